// File: rtl/core_ctrl_pkg.sv
// Shared types for the multicycle control sequencer.
// Holds the sequencer state and instruction-class encodings and the PC step.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HALT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_ALU    = 2'd0,
        OP_LOAD   = 2'd1,
        OP_STORE  = 2'd2,
        OP_BRANCH = 2'd3
    } op_class_t;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/mc_seq_ctrl_outdec.sv
// Combinational output decoder for mc_seq_ctrl.
// Ports: state_i, op_i, mem_ready_i, branch_taken_i in; datapath enables,
// memory request, writeback/PC selects and the retire strobe out.
module mc_seq_outdec
    import core_ctrl_pkg::*;
(
    input  seq_state_t state_i,
    input  op_class_t  op_i,
    input  logic       mem_ready_i,
    input  logic       branch_taken_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       pc_en_o,
    output logic       pc_sel_o,
    output logic       ir_en_o,
    output logic       ab_en_o,
    output logic       alu_en_o,
    output logic       mdr_en_o,
    output logic       rf_we_o,
    output logic       wb_sel_o,
    output logic       retire_o
);

    always_comb begin
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        pc_en_o   = 1'b0;
        pc_sel_o  = 1'b0;
        ir_en_o   = 1'b0;
        ab_en_o   = 1'b0;
        alu_en_o  = 1'b0;
        mdr_en_o  = 1'b0;
        rf_we_o   = 1'b0;
        wb_sel_o  = 1'b0;
        retire_o  = 1'b0;
        case (state_i)
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_en_o = 1'b1;
                    pc_en_o = 1'b1;
                end
            end
            ST_DECODE: ab_en_o = 1'b1;
            ST_EXEC: begin
                alu_en_o = 1'b1;
                if (op_i == OP_BRANCH) begin
                    pc_en_o  = branch_taken_i;
                    pc_sel_o = 1'b1;
                    retire_o = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (op_i == OP_STORE);
                if (mem_ready_i) begin
                    // Only loads continue to WB; anything else ends here.
                    if (op_i == OP_LOAD) mdr_en_o = 1'b1;
                    else                 retire_o = 1'b1;
                end
            end
            ST_WB: begin
                rf_we_o  = 1'b1;
                wb_sel_o = (op_i == OP_LOAD);
                retire_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with halt support.
// Ports: clk, rst (async active-low), halt/op/branch/mem_ready in;
// datapath enables, memory request, state_o and retired_cnt_o out.
module mc_seq_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_i,
    input  logic [1:0]       op_class_i,
    input  logic             branch_taken_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             pc_en_o,
    output logic             pc_sel_o,
    output logic             ir_en_o,
    output logic             ab_en_o,
    output logic             alu_en_o,
    output logic             mdr_en_o,
    output logic             rf_we_o,
    output logic             wb_sel_o,
    output logic             instr_done_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_cnt_o
);

    seq_state_t       state_q, state_d;
    op_class_t        op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    mc_seq_outdec u_outdec (
        .state_i        (state_q),
        .op_i           (op_q),
        .mem_ready_i    (mem_ready_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .pc_en_o        (pc_en_o),
        .pc_sel_o       (pc_sel_o),
        .ir_en_o        (ir_en_o),
        .ab_en_o        (ab_en_o),
        .alu_en_o       (alu_en_o),
        .mdr_en_o       (mdr_en_o),
        .rf_we_o        (rf_we_o),
        .wb_sel_o       (wb_sel_o),
        .retire_o       (retire)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HALT:   if (!halt_i) state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
            ST_DECODE: begin
                op_d    = op_class_t'(op_class_i);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ALU:            state_d = ST_WB;
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
                    default:           state_d = state_q;
                endcase
            end
            ST_MEM: begin
                if (mem_ready_i && op_q == OP_LOAD) state_d = ST_WB;
            end
            ST_WB:   state_d = state_q;
            // Illegal codes fall back to a safe idle state.
            default: state_d = ST_HALT;
        endcase
        // Retirement overrides the per-state successor.
        if (retire) begin
            state_d = halt_i ? ST_HALT : ST_FETCH;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HALT;
            op_q    <= OP_ALU;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_done_o  = retire;
    assign state_o       = state_q;
    assign retired_cnt_o = cnt_q;

endmodule
